// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the I/D memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEF_TIMEOUT    = 16;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and load/store with a fetch-starvation counter.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_req,
  input  logic d_req,
  input  logic grant,
  output logic grant_d
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] CNT_MAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt_reg;

  // D wins ties until fetch has been passed over STARVE_MAX times in a row.
  assign grant_d = d_req && !(i_req && (starve_cnt_reg == CNT_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_reg <= '0;
    end else if (grant) begin
      if (!grant_d) begin
        starve_cnt_reg <= '0;
      end else if (i_req && (starve_cnt_reg != CNT_MAX)) begin
        starve_cnt_reg <= starve_cnt_reg + SW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D) with a
// three-state FSM, one-cycle completion pulses and a BUSY timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_done,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_done,
  output logic [DW-1:0]   d_rdata,
  output logic            err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic              owner_reg, owner_next;
  logic [TW-1:0]     to_cnt_reg, to_cnt_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [AW-1:0]     mem_addr_reg, mem_addr_next;
  logic [DW-1:0]     mem_wdata_reg, mem_wdata_next;
  logic [DW/8-1:0]   mem_wstrb_reg, mem_wstrb_next;
  logic              i_done_reg, i_done_next;
  logic              d_done_reg, d_done_next;
  logic [DW-1:0]     i_rdata_reg, i_rdata_next;
  logic [DW-1:0]     d_rdata_reg, d_rdata_next;
  logic              err_reg, err_next;
  logic [DW-1:0]     cap_data;
  logic              grant;
  logic              grant_d;

  assign grant = (state_reg == IDLE) && (i_req || d_req);

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .reset_n(reset_n),
    .i_req  (i_req),
    .d_req  (d_req),
    .grant  (grant),
    .grant_d(grant_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_I;
      to_cnt_reg    <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
      i_done_reg    <= 1'b0;
      d_done_reg    <= 1'b0;
      i_rdata_reg   <= '0;
      d_rdata_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      to_cnt_reg    <= to_cnt_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_wstrb_reg <= mem_wstrb_next;
      i_done_reg    <= i_done_next;
      d_done_reg    <= d_done_next;
      i_rdata_reg   <= i_rdata_next;
      d_rdata_reg   <= d_rdata_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    to_cnt_next    = to_cnt_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_wstrb_next = mem_wstrb_reg;
    i_done_next    = 1'b0;
    d_done_next    = 1'b0;
    i_rdata_next   = i_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    err_next       = err_reg;
    cap_data       = mem_ack ? mem_rdata : '0;

    case (state_reg)
      IDLE: begin
        if (grant) begin
          state_next   = BUSY;
          owner_next   = grant_d ? OWN_D : OWN_I;
          to_cnt_next  = '0;
          mem_req_next = 1'b1;
          if (grant_d) begin
            mem_we_next    = d_we;
            mem_addr_next  = d_addr;
            mem_wdata_next = d_wdata;
            mem_wstrb_next = d_wstrb;
          end else begin
            mem_we_next    = 1'b0;
            mem_addr_next  = i_addr;
            mem_wdata_next = '0;
            mem_wstrb_next = '0;
          end
        end
      end
      BUSY: begin
        // An ack on the last allowed cycle still counts as a normal completion.
        if (mem_ack || (to_cnt_reg == TO_LAST)) begin
          state_next   = RESP;
          mem_req_next = 1'b0;
          err_next     = !mem_ack;
          if (owner_reg == OWN_D) begin
            d_done_next  = 1'b1;
            d_rdata_next = cap_data;
          end else begin
            i_done_next  = 1'b1;
            i_rdata_next = cap_data;
          end
        end else begin
          to_cnt_next = to_cnt_reg + TW'(1);
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign i_done    = i_done_reg;
  assign d_done    = d_done_reg;
  assign i_rdata   = i_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: vector table with a completion scoreboard, plus
// starvation, late-ack and reset-in-BUSY sequences.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;
  localparam int STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            i_req, d_req, d_we, mem_ack;
  logic [AW-1:0]   i_addr, d_addr;
  logic [DW-1:0]   d_wdata, mem_rdata;
  logic [DW/8-1:0] d_wstrb;
  logic            i_done, d_done, err, mem_req, mem_we;
  logic [DW-1:0]   i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0]   mem_addr;
  logic [DW/8-1:0] mem_wstrb;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            is_d;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    int              delay;     // ack cycles after mem_req rises; >= TIMEOUT means never
    logic [DW-1:0]   mem_data;
    logic [DW-1:0]   exp_rdata;
    logic            exp_err;
  } vec_t;

  typedef struct {
    logic          is_d;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int cyc, req_cycles, bad, done_cyc, exp_done, exp_req;
    logic [68:0] snap;
    exp_t e;
    sb.push_back('{v.is_d, v.exp_rdata, v.exp_err});
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    mem_ack = 1'b0;
    tick();
    cyc = 1; req_cycles = 0; bad = 0; done_cyc = -1;
    chk({nm, "_cmd_req"}, mem_req, 1);
    chk({nm, "_cmd_addr"}, mem_addr, v.addr);
    chk({nm, "_cmd_we"}, mem_we, v.is_d & v.we);
    chk({nm, "_cmd_wstrb"}, mem_wstrb, v.is_d ? v.wstrb : 4'h0);
    if (v.is_d) chk({nm, "_cmd_wdata"}, mem_wdata, v.wdata);
    snap = {mem_we, mem_addr, mem_wdata, mem_wstrb};
    while (cyc < 60) begin
      if (i_done || d_done) begin
        done_cyc = cyc;
        break;
      end
      if (mem_req) begin
        req_cycles++;
        if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== snap) bad++;
      end
      mem_ack   = mem_req && (cyc - 1 == v.delay);
      mem_rdata = mem_ack ? v.mem_data : 32'hA5A5_A5A5;
      tick();
      cyc++;
      mem_ack = 1'b0;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    exp_done = (v.delay >= TIMEOUT) ? TIMEOUT + 1 : v.delay + 2;
    exp_req  = (v.delay >= TIMEOUT) ? TIMEOUT : v.delay + 1;
    chk({nm, "_done_cycle"}, done_cyc, exp_done);
    chk({nm, "_req_cycles"}, req_cycles, exp_req);
    chk({nm, "_cmd_stable"}, bad, 0);
    e = sb.pop_front();
    chk({nm, "_done_port"}, {i_done, d_done}, e.is_d ? 2'b01 : 2'b10);
    chk({nm, "_rdata"}, e.is_d ? d_rdata : i_rdata, e.rdata);
    chk({nm, "_err"}, err, e.err);
    tick();
    chk({nm, "_done_width"}, {i_done, d_done}, 2'b00);
  endtask

  vec_t vecs[6];
  vec_t post_rst;
  logic [0:9] exp_order;

  initial begin
    reset_n = 1'b0; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h0000_0013, 32'h0000_0013, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b0011, 3, 32'h0000_0055, 32'h0000_0055, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0080, 32'h1111_2222, 4'hF, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 2, 32'h0050_0093, 32'h0050_0093, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0090, 32'h0, 4'hF, 15, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_00A0, 32'h0, 4'hF, 99, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    post_rst = '{1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 1, 32'h0000_0ABC, 32'h0000_0ABC, 1'b0};
    exp_order = 10'b1111011110;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_cmd", {mem_we, mem_addr, mem_wdata, mem_wstrb}, 0);
    chk("rst_done", {i_done, d_done}, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    chk("rst_err", err, 0);
    reset_n = 1'b1;
    tick();

    for (int k = 0; k < 6; k++) begin
      run_txn(vecs[k], $sformatf("vec%0d", k));
      $display("vec%0d is_d=%0d addr=0x%0h delay=%0d done, total checks %0d", k,
               vecs[k].is_d, vecs[k].addr, vecs[k].delay, n_total);
    end

    // Late ack two cycles after the timeout completion must be ignored.
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_done", {i_done, d_done}, 0);
    tick();
    chk("late_ack_done2", {i_done, d_done}, 0);
    $display("late ack after timeout: checked");

    // Reset in BUSY drops the transaction with no done pulse.
    i_req = 1'b1; i_addr = 32'h0000_0200;
    tick();
    chk("rstbusy_req_up", mem_req, 1);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("rstbusy_req_async", mem_req, 0);
    i_req = 1'b0;
    tick();
    chk("rstbusy_no_done", {i_done, d_done}, 0);
    tick();
    chk("rstbusy_no_done2", {i_done, d_done}, 0);
    reset_n = 1'b1;
    tick();
    run_txn(post_rst, "post_rst");
    $display("reset in BUSY then fetch: checked");

    // Both requesters held: D four times, then I, repeated.
    i_req = 1'b1; i_addr = 32'h0000_1000;
    d_req = 1'b1; d_addr = 32'h0000_2000; d_we = 1'b0; d_wstrb = 4'hF;
    for (int g = 0; g < 10; g++) begin
      int w;
      logic granted_d;
      w = 0;
      while (!mem_req && w < 20) begin tick(); w++; end
      granted_d = (mem_addr == 32'h0000_2000);
      chk($sformatf("starve_grant%0d", g), granted_d, exp_order[g]);
      mem_ack = 1'b1; mem_rdata = 32'(g);
      tick();
      mem_ack = 1'b0;
      w = 0;
      while (!(i_done || d_done) && w < 20) begin tick(); w++; end
      chk($sformatf("starve_port%0d", g), {i_done, d_done}, granted_d ? 2'b01 : 2'b10);
      $display("starve grant %0d -> %s", g, granted_d ? "D" : "I");
      if (g == 9) begin i_req = 1'b0; d_req = 1'b0; end
    end
    tick();
    tick();
    chk("final_idle", mem_req, 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
